// File: rtl/alu_muldiv.sv
// alu_muldiv: integer execution unit between the RS issue port and the CDB.
// It runs single-cycle integer/compare/JALR ops. It also runs RV32M multiply
// with a fixed latency of MUL_LAT, and divide/remainder on an iterative
// radix-2 divider with latency XLEN+1.
//
// Optional feature macro: ALU_MULDIV_EN
//   defined   -> multiplier and divider present, IDLE/MUL/DIV sequencing.
//   undefined -> opcodes 16-23 return 0 in one cycle; issue_ready tied high.
//
// Ports:
//   clk_in        system clock
//   rst_in        synchronous active-high reset
//   rdy_in        global pause; nothing changes while low
//   clear_signal  misprediction flush (aborts in-flight op, blocks issue)
//   cal_signal    issue request from RS
//   opcode        operation select (0..31)
//   lhs, rhs      operands
//   tag           ROB tag of the issued op
//   issue_ready   unit accepts an op this cycle
//   done_result   one-cycle result-valid pulse
//   value_result  result value (held while done_result is low)
//   tag_result    ROB tag of the result (held while done_result is low)
module alu_muldiv #(
    parameter int XLEN      = 32,
    parameter int ROB_WIDTH = 4,
    parameter int MUL_LAT   = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_signal,
    input  logic                 cal_signal,
    input  logic [4:0]           opcode,
    input  logic [XLEN-1:0]      lhs,
    input  logic [XLEN-1:0]      rhs,
    input  logic [ROB_WIDTH-1:0] tag,
    output logic                 issue_ready,
    output logic                 done_result,
    output logic [XLEN-1:0]      value_result,
    output logic [ROB_WIDTH-1:0] tag_result
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;

    logic [SHW-1:0]       w_shamt;
    logic [XLEN-1:0]      w_sum;
    logic [XLEN-1:0]      w_alu_res;
    logic                 w_fin;
    logic [XLEN-1:0]      w_fin_val;
    logic [ROB_WIDTH-1:0] w_fin_tag;

    assign w_shamt = rhs[SHW-1:0];
    assign w_sum   = lhs + rhs;

    always_comb begin
        w_alu_res = '0;
        case (opcode)
            5'd1:    w_alu_res = lhs & rhs;
            5'd2:    w_alu_res = lhs | rhs;
            5'd3:    w_alu_res = lhs ^ rhs;
            5'd4:    w_alu_res = w_sum;
            5'd5:    w_alu_res = lhs - rhs;
            5'd6:    w_alu_res = lhs >> w_shamt;
            5'd7:    w_alu_res = $signed(lhs) >>> w_shamt;
            5'd8:    w_alu_res = lhs << w_shamt;
            5'd9:    w_alu_res = {XLEN{$signed(lhs) < $signed(rhs)}};
            5'd10:   w_alu_res = {XLEN{lhs < rhs}};
            5'd11:   w_alu_res = {XLEN{lhs == rhs}};
            5'd12:   w_alu_res = {XLEN{lhs != rhs}};
            5'd13:   w_alu_res = {XLEN{$signed(lhs) >= $signed(rhs)}};
            5'd14:   w_alu_res = {XLEN{lhs >= rhs}};
            5'd15:   w_alu_res = {w_sum[XLEN-1:1], 1'b0};
            default: w_alu_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t               r_state, w_state_next;
    logic [CW-1:0]        r_cnt, w_cnt_next;
    logic                 w_accept;
    logic [XLEN-1:0]      r_mul_res, r_quo, r_rem, r_dvs;
    logic                 r_neg_q, r_neg_r, r_sel_rem;
    logic [ROB_WIDTH-1:0] r_tag;

    logic                 w_is_mul, w_is_div;
    logic                 w_lsign, w_rsign;
    logic [2*XLEN-1:0]    w_ma, w_mb, w_prod;
    logic [XLEN-1:0]      w_mul_res;

    logic                 w_div_signed, w_div_rem, w_div_zero, w_div_ovf;
    logic [XLEN-1:0]      w_labs, w_rabs, w_special;
    logic [XLEN:0]        w_shift, w_trial;
    logic [XLEN-1:0]      w_q_step, w_r_step, w_q_fix, w_r_fix;

    assign issue_ready = (r_state == S_IDLE);

    assign w_is_mul = (opcode[4:2] == 3'b100);
    assign w_is_div = (opcode[4:2] == 3'b101);

    // Both operands are extended to 2*XLEN; the low 2*XLEN bits of the
    // product are identical for signed and unsigned interpretations.
    assign w_lsign   = ((opcode == 5'd17) || (opcode == 5'd18)) & lhs[XLEN-1];
    assign w_rsign   = (opcode == 5'd17) & rhs[XLEN-1];
    assign w_ma      = {{XLEN{w_lsign}}, lhs};
    assign w_mb      = {{XLEN{w_rsign}}, rhs};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = (opcode[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    assign w_div_signed = ~opcode[0];
    assign w_div_rem    = opcode[1];
    assign w_div_zero   = (rhs == '0);
    assign w_div_ovf    = w_div_signed & (lhs == {1'b1, {(XLEN-1){1'b0}}}) & (rhs == '1);
    assign w_labs       = (w_div_signed & lhs[XLEN-1]) ? -lhs : lhs;
    assign w_rabs       = (w_div_signed & rhs[XLEN-1]) ? -rhs : rhs;
    assign w_special    = w_div_rem ? (w_div_zero ? lhs : '0) : (w_div_zero ? '1 : lhs);

    // Restoring step: r_quo starts as the dividend and shifts quotient bits
    // in from the bottom while dividend bits leave from the top.
    assign w_shift  = {r_rem, r_quo[XLEN-1]};
    assign w_trial  = w_shift - {1'b0, r_dvs};
    assign w_q_step = {r_quo[XLEN-2:0], ~w_trial[XLEN]};
    assign w_r_step = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
    assign w_q_fix  = r_neg_q ? -w_q_step : w_q_step;
    assign w_r_fix  = r_neg_r ? -w_r_step : w_r_step;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_fin        = 1'b0;
        w_fin_val    = '0;
        w_fin_tag    = r_tag;
        if (rdy_in && clear_signal) begin
            w_state_next = S_IDLE;
        end else if (rdy_in) begin
            case (r_state)
                S_IDLE: begin
                    if (cal_signal) begin
                        w_accept  = 1'b1;
                        w_fin_tag = tag;
                        if (w_is_mul && (MUL_LAT > 1)) begin
                            w_state_next = S_MUL;
                            w_cnt_next   = CW'(MUL_LAT - 2);
                        end else if (w_is_mul) begin
                            w_fin     = 1'b1;
                            w_fin_val = w_mul_res;
                        end else if (w_is_div && !w_div_zero && !w_div_ovf) begin
                            w_state_next = S_DIV;
                            w_cnt_next   = CW'(XLEN - 1);
                        end else if (w_is_div) begin
                            w_fin     = 1'b1;
                            w_fin_val = w_special;
                        end else begin
                            w_fin     = 1'b1;
                            w_fin_val = w_alu_res;
                        end
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
                        w_fin        = 1'b1;
                        w_fin_val    = r_mul_res;
                        w_state_next = S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
                S_DIV: begin
                    if (r_cnt == '0) begin
                        w_fin        = 1'b1;
                        w_fin_val    = r_sel_rem ? w_r_fix : w_q_fix;
                        w_state_next = S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (rdy_in) begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_tag     <= tag;
            r_mul_res <= w_mul_res;
            r_quo     <= w_labs;
            r_rem     <= '0;
            r_dvs     <= w_rabs;
            r_neg_q   <= w_div_signed & (lhs[XLEN-1] ^ rhs[XLEN-1]);
            r_neg_r   <= w_div_signed & lhs[XLEN-1];
            r_sel_rem <= w_div_rem;
        end else if (rdy_in && (r_state == S_DIV)) begin
            r_quo <= w_q_step;
            r_rem <= w_r_step;
        end
    end
`else
    assign issue_ready = 1'b1;
    assign w_fin       = rdy_in & cal_signal & ~clear_signal;
    assign w_fin_val   = w_alu_res;
    assign w_fin_tag   = tag;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            done_result  <= 1'b0;
            value_result <= '0;
            tag_result   <= '0;
        end else if (rdy_in) begin
            done_result <= w_fin;
            if (w_fin) begin
                value_result <= w_fin_val;
                tag_result   <= w_fin_tag;
            end
        end
    end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised successor execution unit for the out-of-order core: single-cycle integer/compare ops plus RV32M multiply (fixed-latency pipeline) and divide/remainder (iterative radix-2). Sits between the RS issue port and the CDB. Returns value and ROB tag to RS, LSB, ROB and I_FETCH. Adds an issue-ready handshake, multi-cycle sequencing and mid-operation flush.

Parameters:
XLEN, 32, datapath width (power of two, >=8)
ROB_WIDTH, 4, ROB tag width
MUL_LAT, 3, multiply latency in cycles (legal 1..4)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset
rdy_in  input  1  global pause; all state frozen when low
clear_signal  input  1  misprediction flush
cal_signal  input  1  issue request from RS
opcode  input  5  operation select (encoding below)
lhs  input  XLEN  operand 1
rhs  input  XLEN  operand 2
tag  input  ROB_WIDTH  ROB tag of issued op
issue_ready  output  1  unit can accept an op this cycle
done_result  output  1  one-cycle result-valid pulse
value_result  output  XLEN  result
tag_result  output  ROB_WIDTH  tag of result

Behaviour:
- Clocking: clk_in only. Reset: synchronous, active-high rst_in, sampled on the rising edge. Reset values: done_result=0, value_result=0, tag_result=0, state=IDLE (issue_ready=1).
- Opcodes: 0 NOP (result 0), 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6 SRL, 7 SRA, 8 SLL, 9 LT, 10 LTU, 11 EQ, 12 NE, 13 GE, 14 GEU, 15 JALR ((lhs+rhs) with bit0 cleared), 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU, 24-31 reserved (treated as NOP).
- Shift amount: rhs[log2(XLEN)-1:0]. Compares return all-ones (true) or zero (false). Add/sub wrap modulo 2^XLEN.
- Multiply: full 2*XLEN-bit product. MUL returns the low half. MULH/MULHSU/MULHU return the high half, with signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
- Divide: DIV/REM truncate toward zero; remainder takes the sign of the dividend.
  - Divisor 0: quotient all-ones, remainder = lhs.
  - DIV/REM with lhs = -2^(XLEN-1) and rhs = -1: quotient = lhs, remainder = 0.
  - Both special cases finish at latency 1.
- Handshake: an op is accepted at a rising edge E0 when rdy_in & cal_signal & issue_ready & ~clear_signal. cal_signal while issue_ready=0 is ignored; RS must hold the op.
- Latency L, counted in edges from E0: done_result is high in the cycle after edge E0+L-1.
  - Single-cycle and reserved ops: L=1.
  - MUL*: L=MUL_LAT.
  - DIV*/REM* (non-special): L=XLEN+1 (1 cycle setup with absolute values, XLEN shift-subtract steps, sign fix in the final step).
- State machine IDLE/MUL/DIV:
  - IDLE -> MUL or DIV on accept of a multi-cycle op.
  - MUL/DIV -> IDLE on the edge that raises done_result.
  - issue_ready = (state==IDLE), so back-to-back issue is possible in the done cycle.
  - A down-counter tracks remaining steps.
- done_result is a single-cycle pulse, cleared on the next active edge unless a new result completes. tag_result and value_result hold their last values while done_result=0.
- rdy_in=0: no state, counter or output changes. clear_signal is ignored too.
- rdy_in & clear_signal at an edge: abort any in-flight op, state->IDLE, done_result<=0, the same-edge cal_signal is not accepted. A result completing on that same edge is dropped.
- rst_in mid-operation: abort, return to reset values.

Optional Feature:
Macro ALU_MULDIV_EN.
- Defined: full behaviour above.
- Undefined: no multiplier or divider is instantiated. Opcodes 16-23 behave as NOP (result 0, L=1). The state machine stays permanently in IDLE and issue_ready is constant 1.

Test Plan:
- After reset: issue ADD lhs=7, rhs=0xFFFFFFFF, tag=3 -> next cycle done_result=1, value=6, tag_result=3. Following cycle done_result=0.
- SRA lhs=0x80000000, rhs=0x24 (shift 4) -> 0xF8000000. LT -1 vs 1 -> 0xFFFFFFFF. LTU -1 vs 1 -> 0. JALR 0x1001 + 0x2 -> 0x1002.
- MULH 0x80000000 * 0x80000000 with MUL_LAT=3 -> issue_ready=0 for 2 cycles, done in 3rd cycle with value 0x40000000. MULHSU -1 * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> done after 33 edges with value 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 5/0 -> 0xFFFFFFFF at L=1. DIV 0x80000000/-1 -> 0x80000000 at L=1.
- Start DIV, assert clear_signal at step 10 together with cal_signal(ADD) -> no done pulse, issue_ready=1 next cycle, the ADD is not executed. A new ADD then completes normally.
- Hold rdy_in=0 for 5 cycles during a MUL -> done is delayed by exactly 5 cycles and the value is correct. Without ALU_MULDIV_EN, MUL 3*4 -> value 0 in 1 cycle.
